// File: rtl/uart_cmd_responder.sv
// Byte-level command responder: decodes 'W'/'R'/'V' commands from the UART
// receiver, serves a 16x8 register file and queues one reply byte per command.
module uart_cmd_responder #(
  parameter logic [7:0]  VERSION = 8'hA5,
  parameter int unsigned TIMEOUT = 100000
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic [7:0] rx_byte,
  input  logic       rbyte_ready,
  input  logic       busy,
  output logic [7:0] sbyte,
  output logic       send,
  output logic       wr_stb,
  output logic [3:0] wr_addr,
  output logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    TX_START,
    TX_HOLD,
    TX_WAIT
  } state_t;

  localparam logic [7:0]  OP_W        = 8'h57;
  localparam logic [7:0]  OP_R        = 8'h52;
  localparam logic [7:0]  OP_V        = 8'h56;
  localparam logic [7:0]  RSP_K       = 8'h4B;
  localparam logic [7:0]  RSP_E       = 8'h45;
  localparam logic [7:0]  RSP_Q       = 8'h3F;
  localparam logic [23:0] TIMEOUT_CNT = 24'(TIMEOUT);

  logic [7:0]  regs [16];
  state_t      state;
  logic [7:0]  opcode;
  logic [7:0]  reply;
  logic [3:0]  addr;
  logic        addr_ok;
  logic [23:0] timer;
  logic        addr_in_range;

  assign addr_in_range = (rx_byte[7:4] == 4'h0);
  assign rd_data       = regs[rd_addr];

  always_ff @(posedge clk100) begin
    if (reset) begin
      state   <= IDLE;
      opcode  <= '0;
      reply   <= '0;
      addr    <= '0;
      addr_ok <= 1'b0;
      timer   <= '0;
      send    <= 1'b0;
      sbyte   <= '0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      // NOTE: the register file is reset too, since rd_data must read 00 one
      // clock after reset; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      // NOTE: every state update here is non-blocking so all branches see the
      // pre-edge values of state, timer and regs.
      wr_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (rbyte_ready) begin
            timer <= '0;
            if (rx_byte == OP_W || rx_byte == OP_R) begin
              opcode <= rx_byte;
              state  <= GET_ADDR;
            end else begin
              reply <= (rx_byte == OP_V) ? VERSION : RSP_Q;
              state <= TX_START;
            end
          end
        end
        GET_ADDR: begin
          if (rbyte_ready) begin
            timer <= '0;
            if (opcode == OP_R) begin
              reply <= addr_in_range ? regs[rx_byte[3:0]] : RSP_E;
              state <= TX_START;
            end else begin
              // An out-of-range write address still consumes its data byte.
              addr    <= rx_byte[3:0];
              addr_ok <= addr_in_range;
              state   <= GET_DATA;
            end
          end else if (timer == TIMEOUT_CNT) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        GET_DATA: begin
          if (rbyte_ready) begin
            timer <= '0;
            if (addr_ok) begin
              regs[addr] <= rx_byte;
              wr_stb     <= 1'b1;
              wr_addr    <= addr;
              wr_data    <= rx_byte;
              reply      <= RSP_K;
            end else begin
              reply <= RSP_E;
            end
            state <= TX_START;
          end else if (timer == TIMEOUT_CNT) begin
            timer <= '0;
            state <= IDLE;
          end else begin
            timer <= timer + 24'd1;
          end
        end
        TX_START: begin
          if (!busy) begin
            send  <= 1'b1;
            sbyte <= reply;
            state <= TX_HOLD;
          end
        end
        TX_HOLD: begin
          // Gives the transmitter one clock to raise busy before we look at it.
          send  <= 1'b0;
          state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
